// File: rtl/vid_timing_gen.sv
// vid_timing_gen - programmable raster timing engine.
//
// Holds the control/timing register file, counts pixels and lines on a
// divided pixel tick, decodes sync/blank/pixel-valid and issues one
// line-fetch request per displayed line to the pixel fetch logic.
// Timing registers are double-buffered: software writes the live copy,
// and the engine only uses it after a frame boundary.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   wr_en        register write strobe
//   wr_addr      register byte offset
//   wr_data      register write data
//   line_ack     fetch logic accepted line_req
//   hsync/vsync  sync outputs, programmable polarity
//   hblank/vblank  blanking, active high
//   pix_valid    one-cycle strobe per displayed pixel
//   hcount/vcount  pixel column / line, aligned with the decoded outputs
//   frame_start  one-cycle pulse at pixel (0,0)
//   line_req     line fetch request, held until line_ack
//   line_addr    start address of the requested line
//   busy         engine is running or finishing a frame after stop
module vid_timing_gen #(
    parameter int CW  = 13,
    parameter int AW  = 32,
    parameter int PDW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_addr,
    input  logic [AW-1:0] wr_data,
    input  logic          line_ack,
    output logic          hsync,
    output logic          hblank,
    output logic          vsync,
    output logic          vblank,
    output logic          pix_valid,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          frame_start,
    output logic          line_req,
    output logic [AW-1:0] line_addr,
    output logic          busy
);

    localparam logic [7:0] ADDR_CR      = 8'h00;
    localparam logic [7:0] ADDR_H1      = 8'h28;
    localparam logic [7:0] ADDR_H2      = 8'h30;
    localparam logic [7:0] ADDR_V1      = 8'h38;
    localparam logic [7:0] ADDR_V2      = 8'h40;
    localparam logic [7:0] ADDR_BASE    = 8'h48;
    localparam logic [7:0] ADDR_LINEINC = 8'h50;

    localparam logic [CW-1:0]  CW_ONE  = CW'(1);
    localparam logic [PDW-1:0] PDW_ONE = PDW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Live register file
    logic           cr_en_reg, cr_hpol_reg, cr_vpol_reg;
    logic [PDW-1:0] cr_pcnt_reg;
    logic [CW-1:0]  hend_reg, hsize_reg, hs_end_reg, hs_start_reg;
    logic [CW-1:0]  vend_reg, vsize_reg, vs_end_reg, vs_start_reg;
    logic [AW-1:0]  base_reg, lineinc_reg;

    // Frame-latched copies used by the engine. BASE has no separate shadow:
    // its only consumer, addr_acc, latches it at exactly the shadow-load points.
    logic [CW-1:0]  hend_sh_reg, hsize_sh_reg, hs_end_sh_reg, hs_start_sh_reg;
    logic [CW-1:0]  vend_sh_reg, vsize_sh_reg, vs_end_sh_reg, vs_start_sh_reg;
    logic [AW-1:0]  lineinc_sh_reg;

    // Counters
    logic [PDW-1:0] presc_reg;
    logic [CW-1:0]  h_cnt_reg, v_cnt_reg;

    // Registered outputs
    logic           hsync_reg, vsync_reg, hblank_reg, vblank_reg;
    logic           pix_valid_reg, frame_start_reg;
    logic [CW-1:0]  hcount_reg, vcount_reg;

    // Line fetch
    logic [AW-1:0]  addr_acc_reg, line_addr_reg;
    logic           line_req_reg;

    logic           tick, line_wrap, frame_wrap, shadow_load;
    logic [CW-1:0]  h_next_val, v_next_val;
    logic           h_disp, v_disp, hs_win, vs_win;
    logic           req_event, ack_fire;
    logic [AW-1:0]  acc_after_ack, acc_next, addr_next;
    logic           req_next;

    logic           wr_data_unused;
    assign wr_data_unused = ^wr_data;

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            cr_en_reg    <= 1'b0;
            cr_hpol_reg  <= 1'b0;
            cr_vpol_reg  <= 1'b0;
            cr_pcnt_reg  <= '0;
            hend_reg     <= '0;
            hsize_reg    <= '0;
            hs_end_reg   <= '0;
            hs_start_reg <= '0;
            vend_reg     <= '0;
            vsize_reg    <= '0;
            vs_end_reg   <= '0;
            vs_start_reg <= '0;
            base_reg     <= '0;
            lineinc_reg  <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_CR: begin
                    cr_en_reg   <= wr_data[3];
                    cr_pcnt_reg <= wr_data[4 +: PDW];
                    cr_hpol_reg <= wr_data[16];
                    cr_vpol_reg <= wr_data[17];
                end
                ADDR_H1: begin
                    hend_reg  <= wr_data[0 +: CW];
                    hsize_reg <= wr_data[CW +: CW];
                end
                ADDR_H2: begin
                    hs_end_reg   <= wr_data[0 +: CW];
                    hs_start_reg <= wr_data[CW +: CW];
                end
                ADDR_V1: begin
                    vend_reg  <= wr_data[0 +: CW];
                    vsize_reg <= wr_data[CW +: CW];
                end
                ADDR_V2: begin
                    vs_end_reg   <= wr_data[0 +: CW];
                    vs_start_reg <= wr_data[CW +: CW];
                end
                ADDR_BASE:    base_reg    <= wr_data;
                ADDR_LINEINC: lineinc_reg <= wr_data;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tick and counter next values
    // ------------------------------------------------------------------
    assign tick        = (state_reg != IDLE) && (presc_reg == cr_pcnt_reg);
    assign h_next_val  = (h_cnt_reg == hend_sh_reg) ? '0 : h_cnt_reg + CW_ONE;
    assign v_next_val  = (v_cnt_reg == vend_sh_reg) ? '0 : v_cnt_reg + CW_ONE;
    assign line_wrap   = tick && (h_cnt_reg == hend_sh_reg);
    assign frame_wrap  = line_wrap && (v_cnt_reg == vend_sh_reg);
    assign shadow_load = ((state_reg == IDLE) && cr_en_reg) || frame_wrap;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (cr_en_reg) state_next = RUN;
            RUN:  if (!cr_en_reg) state_next = STOP;
            STOP: begin
                if (cr_en_reg)       state_next = RUN;
                else if (frame_wrap) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow registers (non-blocking: a same-edge write lands next frame)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            hend_sh_reg     <= '0;
            hsize_sh_reg    <= '0;
            hs_end_sh_reg   <= '0;
            hs_start_sh_reg <= '0;
            vend_sh_reg     <= '0;
            vsize_sh_reg    <= '0;
            vs_end_sh_reg   <= '0;
            vs_start_sh_reg <= '0;
            lineinc_sh_reg  <= '0;
        end else if (shadow_load) begin
            hend_sh_reg     <= hend_reg;
            hsize_sh_reg    <= hsize_reg;
            hs_end_sh_reg   <= hs_end_reg;
            hs_start_sh_reg <= hs_start_reg;
            vend_sh_reg     <= vend_reg;
            vsize_sh_reg    <= vsize_reg;
            vs_end_sh_reg   <= vs_end_reg;
            vs_start_sh_reg <= vs_start_reg;
            lineinc_sh_reg  <= lineinc_reg;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset || (state_reg == IDLE)) begin
            presc_reg <= '0;
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            // >= so that lowering pcnt while running cannot strand the prescaler
            presc_reg <= (presc_reg >= cr_pcnt_reg) ? '0 : presc_reg + PDW_ONE;
            if (tick) begin
                h_cnt_reg <= h_next_val;
                if (line_wrap) v_cnt_reg <= v_next_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode: registered, hcount/vcount outputs delayed with them
    // ------------------------------------------------------------------
    assign h_disp = h_cnt_reg < hsize_sh_reg;
    assign v_disp = v_cnt_reg < vsize_sh_reg;
    assign hs_win = (h_cnt_reg >= hs_start_sh_reg) && (h_cnt_reg < hs_end_sh_reg);
    assign vs_win = (v_cnt_reg >= vs_start_sh_reg) && (v_cnt_reg < vs_end_sh_reg);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            hblank_reg      <= 1'b1;
            vblank_reg      <= 1'b1;
            pix_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            hcount_reg      <= '0;
            vcount_reg      <= '0;
        end else if (state_reg == IDLE) begin
            hsync_reg       <= cr_hpol_reg;
            vsync_reg       <= cr_vpol_reg;
            hblank_reg      <= 1'b1;
            vblank_reg      <= 1'b1;
            pix_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            hcount_reg      <= '0;
            vcount_reg      <= '0;
        end else begin
            hsync_reg       <= hs_win ^ cr_hpol_reg;
            vsync_reg       <= vs_win ^ cr_vpol_reg;
            hblank_reg      <= !h_disp;
            vblank_reg      <= !v_disp;
            pix_valid_reg   <= tick && h_disp && v_disp;
            frame_start_reg <= tick && (h_cnt_reg == '0) && (v_cnt_reg == '0);
            hcount_reg      <= h_cnt_reg;
            vcount_reg      <= v_cnt_reg;
        end
    end

    // ------------------------------------------------------------------
    // Line fetch requests. The request made during line v is for line v+1,
    // so line 0 of the next frame is requested while vcount == vend.
    // ------------------------------------------------------------------
    assign req_event     = tick && (h_next_val == hsize_sh_reg) && (v_next_val < vsize_sh_reg);
    assign ack_fire      = line_req_reg && line_ack;
    assign acc_after_ack = ack_fire ? addr_acc_reg + lineinc_sh_reg : addr_acc_reg;

    always_comb begin
        acc_next  = acc_after_ack;
        req_next  = line_req_reg && !line_ack;
        addr_next = line_addr_reg;
        if (req_event) begin
            if (line_req_reg && !line_ack) begin
                // previous request still pending: drop this line, skip its address
                acc_next = acc_after_ack + lineinc_sh_reg;
            end else begin
                req_next  = 1'b1;
                addr_next = acc_after_ack;
            end
        end
        // base_reg is the value the timing shadows latch on this same edge
        if (frame_wrap) acc_next = base_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_acc_reg  <= '0;
            line_addr_reg <= '0;
            line_req_reg  <= 1'b0;
        end else if (state_reg == IDLE) begin
            line_req_reg <= 1'b0;
            if (cr_en_reg) addr_acc_reg <= base_reg;
        end else begin
            addr_acc_reg  <= acc_next;
            line_addr_reg <= addr_next;
            line_req_reg  <= req_next;
        end
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign hblank      = hblank_reg;
    assign vblank      = vblank_reg;
    assign pix_valid   = pix_valid_reg;
    assign frame_start = frame_start_reg;
    assign hcount      = hcount_reg;
    assign vcount      = vcount_reg;
    assign line_req    = line_req_reg;
    assign line_addr   = line_addr_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_vid_timing_gen.sv
// tb_vid_timing_gen - self-checking bench for vid_timing_gen.
// Timing setup: hend=9 hsize=7 hsync 8..9, vend=4 vsize=3 vsync 3..4,
// BASE=0x1000 LINEINC=0x280. Line addresses are checked from a queue of
// expected values filled when the engine is enabled.
module tb_vid_timing_gen;
    localparam int CW  = 13;
    localparam int AW  = 32;
    localparam int PDW = 6;

    localparam logic [7:0] A_CR = 8'h00, A_H1 = 8'h28, A_H2 = 8'h30;
    localparam logic [7:0] A_V1 = 8'h38, A_V2 = 8'h40, A_BASE = 8'h48, A_INC = 8'h50;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_addr = '0;
    logic [AW-1:0] wr_data = '0;
    logic          line_ack = 1'b0;
    logic          hsync, hblank, vsync, vblank, pix_valid, frame_start, line_req, busy;
    logic [CW-1:0] hcount, vcount;
    logic [AW-1:0] line_addr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [AW-1:0] exp_q[$];

    vid_timing_gen #(.CW(CW), .AW(AW), .PDW(PDW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .line_ack(line_ack), .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
        .pix_valid(pix_valid), .hcount(hcount), .vcount(vcount), .frame_start(frame_start),
        .line_req(line_req), .line_addr(line_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance to the next sampling point; acknowledge requests one cycle later.
    task automatic step();
        @(negedge clk);
        line_ack = line_req;
    endtask

    task automatic wr(input logic [7:0] a, input logic [AW-1:0] d);
        step();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    function automatic logic [AW-1:0] pack2(input int hi, input int lo);
        logic [AW-1:0] w;
        w = '0;
        w[0 +: CW]  = CW'(lo);
        w[CW +: CW] = CW'(hi);
        return w;
    endfunction

    function automatic logic [AW-1:0] cr_word(input bit en, input int pcnt, input bit hpol, input bit vpol);
        logic [AW-1:0] w;
        w = '0;
        w[3] = en;
        w[4 +: PDW] = PDW'(pcnt);
        w[16] = hpol;
        w[17] = vpol;
        return w;
    endfunction

    task automatic test_reset();
        logic [7:0] flags;
        reset = 1'b0;
        repeat (3) step();
        flags = {hsync, vsync, hblank, vblank, pix_valid, frame_start, line_req, busy};
        n_cmp++;
        if (flags !== 8'b0011_0000) begin n_bad++; $display("FAIL reset_flags: got %b expected %b", flags, 8'b0011_0000); end
        n_cmp++;
        if (hcount !== '0 || vcount !== '0) begin n_bad++; $display("FAIL reset_counts: got h=%0d v=%0d expected 0/0", hcount, vcount); end
        n_cmp++;
        if (line_addr !== '0) begin n_bad++; $display("FAIL reset_line_addr: got %h expected 0", line_addr); end
        reset = 1'b1;
        step(); step();
        flags = {hsync, vsync, hblank, vblank, pix_valid, frame_start, line_req, busy};
        n_cmp++;
        if (flags !== 8'b0011_0000) begin n_bad++; $display("FAIL idle_flags: got %b expected %b", flags, 8'b0011_0000); end
        $display("reset: outputs checked");
    endtask

    task automatic program_timing();
        wr(A_H1, pack2(7, 9));
        wr(A_H2, pack2(8, 9));
        wr(A_V1, pack2(3, 4));
        wr(A_V2, pack2(3, 4));
        wr(A_BASE, 32'h0000_1000);
        wr(A_INC, 32'h0000_0280);
    endtask

    // Full-frame checks against a raster model, for pcnt=2 then pcnt=0.
    task automatic test_timing_and_fetch();
        logic [2*CW+5:0] obs, expv;
        logic [AW-1:0] ea;
        int p, fc, nfs, pix_cnt, h, v, frame_len;
        bit synced, prev_req, last, ok;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? 3 : 1;
            frame_len = 50 * p;
            if (busy) begin
                wr(A_CR, cr_word(0, 0, 0, 0));
                ok = 0;
                for (int c = 0; c < 400; c++) begin step(); if (!busy) begin ok = 1; break; end end
                n_cmp++;
                if (!ok) begin n_bad++; $display("FAIL timing_idle_wait: busy=%b expected 0 within 400 cycles", busy); end
            end
            for (int f = 0; f < 3; f++) begin
                exp_q.push_back(32'h1000); exp_q.push_back(32'h1280); exp_q.push_back(32'h1500);
            end
            wr(A_CR, cr_word(1, p - 1, 0, 0));
            synced = 0; fc = 0; nfs = 0; pix_cnt = 0; prev_req = 0;
            for (int c = 0; c < 5 * frame_len + 200 && nfs < 4; c++) begin
                step();
                if (!synced && frame_start) begin synced = 1; fc = p - 1; end
                if (synced) begin
                    if (frame_start) begin
                        if (nfs > 0) begin
                            n_cmp++;
                            if (pix_cnt != 21) begin n_bad++; $display("FAIL pix_per_frame: got %0d expected 21 (pcnt=%0d)", pix_cnt, p - 1); end
                        end
                        nfs++;
                        pix_cnt = 0;
                    end
                    h = (fc / p) % 10;
                    v = (fc / p) / 10;
                    last = (fc % p) == (p - 1);
                    expv = {CW'(h), CW'(v), (h >= 7), (v >= 3), (h == 8), (v == 3),
                            (last && h < 7 && v < 3), (fc == p - 1)};
                    obs = {hcount, vcount, hblank, vblank, hsync, vsync, pix_valid, frame_start};
                    n_cmp++;
                    if (obs !== expv) begin
                        n_bad++;
                        $display("FAIL raster pcnt=%0d fc=%0d: got h=%0d v=%0d hb/vb/hs/vs/pv/fs=%b expected h=%0d v=%0d %b",
                                 p - 1, fc, hcount, vcount, obs[5:0], h, v, expv[5:0]);
                    end
                    if (pix_valid) pix_cnt++;
                    fc = (fc + 1) % frame_len;
                end
                if (line_req && !prev_req) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++; $display("FAIL line_addr_extra: got request at %h expected none", line_addr);
                    end else begin
                        ea = exp_q.pop_front();
                        if (line_addr !== ea) begin n_bad++; $display("FAIL line_addr: got %h expected %h", line_addr, ea); end
                        else $display("line_req addr=%h ok", line_addr);
                    end
                end
                prev_req = line_req;
            end
            n_cmp++;
            if (nfs < 4) begin n_bad++; $display("FAIL frame_timeout: got %0d frame_starts expected 4", nfs); end
            n_cmp++;
            if (exp_q.size() != 0) begin n_bad++; $display("FAIL line_req_missing: %0d requests outstanding expected 0", exp_q.size()); end
            exp_q.delete();
            $display("timing pcnt=%0d: %0d frames observed", p - 1, nfs);
        end
    endtask

    task automatic test_midframe_hsize();
        int nfs, lim;
        bit ok;
        ok = 0;
        for (int c = 0; c < 200; c++) begin step(); if (vcount == 1 && hcount == 0) begin ok = 1; break; end end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL midframe_wait: got v=%0d h=%0d expected 1/0", vcount, hcount); end
        wr(A_H1, pack2(5, 9));
        nfs = 0;
        for (int c = 0; c < 200 && nfs < 2; c++) begin
            step();
            if (frame_start) nfs++;
            lim = (nfs > 0) ? 5 : 7;
            n_cmp++;
            if (hblank !== (hcount >= CW'(lim))) begin
                n_bad++; $display("FAIL midframe_hblank: got hblank=%b at h=%0d expected %b (hsize %0d)", hblank, hcount, hcount >= CW'(lim), lim);
            end
        end
        n_cmp++;
        if (nfs < 2) begin n_bad++; $display("FAIL midframe_timeout: got %0d frame_starts expected 2", nfs); end
        wr(A_H1, pack2(7, 9));
        $display("midframe hsize: switch checked");
    endtask

    task automatic test_polarity();
        bit ok;
        wr(A_CR, cr_word(1, 0, 1, 1));
        step();
        for (int c = 0; c < 60; c++) begin
            step();
            n_cmp++;
            if ({hsync, vsync} !== {hcount != 8, vcount != 3}) begin
                n_bad++; $display("FAIL polarity_run: got hs=%b vs=%b at h=%0d v=%0d expected %b %b", hsync, vsync, hcount, vcount, hcount != 8, vcount != 3);
            end
        end
        wr(A_CR, cr_word(0, 0, 1, 1));
        ok = 0;
        for (int c = 0; c < 200; c++) begin step(); if (!busy) begin ok = 1; break; end end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL polarity_stop_wait: busy=%b expected 0", busy); end
        step();
        n_cmp++;
        if ({hsync, vsync, hblank, vblank, busy} !== 5'b11110) begin
            n_bad++; $display("FAIL polarity_idle: got hs/vs/hb/vb/busy=%b expected 11110", {hsync, vsync, hblank, vblank, busy});
        end
        $display("polarity: checked");
    endtask

    task automatic test_stop();
        bit ok;
        wr(A_CR, cr_word(1, 0, 0, 0));
        ok = 0;
        for (int c = 0; c < 200; c++) begin step(); if (vcount == 1) begin ok = 1; break; end end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL stop_wait_v1: got v=%0d expected 1", vcount); end
        wr(A_CR, cr_word(0, 0, 0, 0));
        ok = 0;
        for (int c = 0; c < 200; c++) begin step(); if (!busy) begin ok = 1; break; end end
        n_cmp++;
        if (!ok || hcount !== CW'(9) || vcount !== CW'(4)) begin
            n_bad++; $display("FAIL stop_at_wrap: got busy drop=%0d at h=%0d v=%0d expected at 9/4", ok, hcount, vcount);
        end
        step();
        n_cmp++;
        if ({hblank, vblank, busy} !== 3'b110 || hcount !== '0 || vcount !== '0) begin
            n_bad++; $display("FAIL stop_idle: got hb/vb/busy=%b h=%0d v=%0d expected 110 0 0", {hblank, vblank, busy}, hcount, vcount);
        end
        $display("stop: checked");
    endtask

    task automatic test_reset_midline();
        bit ok;
        wr(A_CR, cr_word(1, 0, 1, 0));
        ok = 0;
        for (int c = 0; c < 200; c++) begin step(); if (vcount == 2 && hcount == 4) begin ok = 1; break; end end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rst_wait: got v=%0d h=%0d expected 2/4", vcount, hcount); end
        reset = 1'b0;
        step();
        n_cmp++;
        if ({hsync, vsync, hblank, vblank, pix_valid, frame_start, line_req, busy} !== 8'b0011_0000) begin
            n_bad++; $display("FAIL rst_mid_flags: got %b expected 00110000", {hsync, vsync, hblank, vblank, pix_valid, frame_start, line_req, busy});
        end
        n_cmp++;
        if (hcount !== '0 || vcount !== '0 || line_addr !== '0) begin
            n_bad++; $display("FAIL rst_mid_values: got h=%0d v=%0d addr=%h expected 0", hcount, vcount, line_addr);
        end
        reset = 1'b1;
        step(); step();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_cr_cleared: got busy=%b expected 0", busy); end
        // timing registers were cleared too: hend=vend=0, hsize=vsize=0
        wr(A_CR, cr_word(1, 0, 0, 0));
        repeat (3) step();
        n_cmp++;
        if ({hblank, vblank} !== 2'b11 || hcount !== '0 || vcount !== '0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL rst_regs_cleared: got hb/vb=%b h=%0d v=%0d busy=%b expected 11 0 0 1", {hblank, vblank}, hcount, vcount, busy);
        end
        $display("reset mid-line: checked");
    endtask

    initial begin
        test_reset();
        program_timing();
        test_timing_and_fetch();
        test_midframe_hsize();
        test_polarity();
        test_stop();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vid_timing_gen.md
Name: vid_timing_gen

Overview:
- Parametrised second-generation raster timing engine for the video controller.
- Holds the programmable control and timing register file (CR, H1, H2, V1, V2, BASE, LINEINC). Generates pixel-divided hsync/hblank/vsync/vblank with programmable polarity.
- Issues one line-fetch request per displayed line, carrying the computed line start address, to the downstream pixel fetch/FIFO logic.
- Timing registers are double-buffered and take effect only at frame boundaries, so software can reprogram mid-frame without tearing.

Parameters:
- CW, 13, width of every horizontal/vertical counter and timing field (1..16).
- AW, 32, width of the address/data bus, BASE, LINEINC and line_addr.
- PDW, 6, width of the pixel-clock divider field CR.pcnt.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  register write strobe, one write per cycle.
- wr_addr  in  8  register byte offset.
- wr_data  in  AW  register write data.
- line_ack  in  1  fetch logic accepted line_req.
- hsync  out  1  horizontal sync, polarity applied.
- hblank  out  1  horizontal blanking, active high.
- vsync  out  1  vertical sync, polarity applied.
- vblank  out  1  vertical blanking, active high.
- pix_valid  out  1  one-cycle strobe per displayed pixel.
- hcount  out  CW  current pixel column.
- vcount  out  CW  current line.
- frame_start  out  1  one-cycle pulse at pixel (0,0).
- line_req  out  1  line fetch request; held until line_ack.
- line_addr  out  AW  start address of the requested line; stable while line_req is high.
- busy  out  1  engine is in RUN or STOP.

Behaviour:
- Reset (reset==0 at posedge clk): all registers, shadows and counters = 0; state = IDLE; hsync = vsync = 0; hblank = vblank = 1; all other outputs 0.
- Register map (write-only; unmapped offsets ignored):
  - 0x00 CR: [3] en, [4+PDW-1:4] pcnt, [16] hpol, [17] vpol.
  - 0x28 H1: [CW-1:0] hend, [2CW-1:CW] hsize.
  - 0x30 H2: [CW-1:0] hsync_end, [2CW-1:CW] hsync_start.
  - 0x38 V1: [CW-1:0] vend, [2CW-1:CW] vsize.
  - 0x40 V2: [CW-1:0] vsync_end, [2CW-1:CW] vsync_start.
  - 0x48 BASE; 0x50 LINEINC.
- Write timing: a write updates the live register on the next edge. CR takes effect immediately. All other registers are copied to shadows only at the IDLE->RUN transition and at each frame wrap (hcount==hend && vcount==vend on a tick).
- Simultaneous write and shadow load: the shadow receives the pre-write value; the new value applies from the next frame.
- Pixel divider: prescaler counts 0..pcnt; tick = (prescaler==pcnt). pcnt=0 gives a tick every clk.
- Counters advance on tick only:
  - hcount wraps hend -> 0.
  - On that wrap, vcount increments and wraps vend -> 0.
- State machine:
  - IDLE: counters held at 0; hsync = hpol, vsync = vpol, blanks = 1. Moves to RUN when en==1; shadows load on the same edge.
  - RUN: counting. en==0 moves to STOP.
  - STOP: continues counting until the frame wrap, then enters IDLE. en re-set during STOP returns to RUN with no discontinuity.
- Decode (all outputs registered, 1 clk after the counter value):
  - hblank = (hcount >= hsize); vblank = (vcount >= vsize).
  - hsync = (hsync_start <= hcount < hsync_end) XOR hpol; vsync likewise with vpol.
  - start == end gives no sync pulse.
  - pix_valid = tick && !hblank && !vblank.
  - frame_start = tick at (0,0).
- Line fetch:
  - Internal addr_acc is loaded with BASE shadow at each frame wrap and at IDLE->RUN.
  - line_req rises on the tick where hcount becomes hsize and the next line (vcount+1, or 0 at vend) is < vsize. The line-0 request issues at vcount==vend.
  - line_addr = addr_acc. On line_ack && line_req: addr_acc += LINEINC (modulo 2^AW); line_req drops the next cycle.
  - A new request arriving while the previous one is unacked is dropped and its address skipped (addr_acc still += LINEINC).
- Degenerate programming:
  - hsize > hend: hblank never asserts.
  - vsize == 0: no line_req.
  - hend == 0: one pixel per line.
- Reset mid-frame forces the reset values above on the next edge.

Test Plan:
- Program H1 hend=9,hsize=7; H2 12/10? no: hsync_start=8,hsync_end=9; V1 vend=4,vsize=3; V2 3/4; pcnt=0, en=1 -> hcount cycles 0..9; hblank high for hcount 7..9; hsync high at hcount 8 only; pix_valid count per frame = 21; frame_start every 50 clks.
- Same setup with pcnt=2 -> each hcount value held 3 clks; frame period 150 clks.
- BASE=0x1000, LINEINC=0x280, line_ack one cycle after each req -> line_addr sequence 0x1000, 0x1280, 0x1500, then 0x1000 for the next frame.
- Write hsize=5 at mid-frame (vcount=1) -> hblank still starts at hcount 7 until the frame wrap, then at hcount 5.
- hpol=1, vpol=1 -> hsync low only at hcount 8; in IDLE both hsync and vsync high.
- Clear en at vcount=1 -> busy stays high until the frame wrap, then IDLE with blanks=1. Apply reset mid-line -> all outputs at reset values on the next edge.
